// File: rtl/phy_tx_lane_sched.sv
// Purpose : round-robin byte scheduler for the PHY transmitter: COM sync burst, then 4-source RR with IDL/SKP fill.
// Latency : granted byte appears on data_out one clk after valid_in[i] && ready_out[i].
// Backpr. : ready_out (combinational) is one-hot or zero; it is zero outside ACTIVE, on SKP cycles and when enable is low.
//
// Ports   : clk, reset (async, active-high), enable; in0..in3 + valid_in[3:0] / ready_out[3:0] source handshake;
//           data_out, valid_out, k_char, lane_sel (registered byte stream); state_out (00 IDLE, 01 SYNC, 10 ACTIVE), sync_done.
// Option  : define PHY_TX_SCHED_STATS_EN to add saturating per-source byte counters cnt0..cnt3 and SKP counter skp_cnt.
module phy_tx_lane_sched #(
    parameter int          SYNC_COUNT   = 4,
    parameter int          SKP_INTERVAL = 16,
    parameter logic [7:0]  COM_SYM      = 8'hBC,
    parameter logic [7:0]  IDL_SYM      = 8'h7C,
    parameter logic [7:0]  SKP_SYM      = 8'h1C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  in0,
    input  logic [7:0]  in1,
    input  logic [7:0]  in2,
    input  logic [7:0]  in3,
    input  logic [3:0]  valid_in,
    output logic [3:0]  ready_out,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        k_char,
    output logic [1:0]  lane_sel,
    output logic [1:0]  state_out,
    output logic        sync_done
`ifdef PHY_TX_SCHED_STATS_EN
    ,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1,
    output logic [15:0] cnt2,
    output logic [15:0] cnt3,
    output logic [15:0] skp_cnt
`endif
);

    localparam int SC_W  = $clog2(SYNC_COUNT + 1);
    localparam int SKP_W = $clog2(SKP_INTERVAL);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SYNC   = 2'b01,
        ST_ACTIVE = 2'b10
    } state_t;

    state_t           r_state;
    logic [SC_W-1:0]  r_sync_cnt;
    logic [SKP_W-1:0] r_skp_cnt;
    logic [1:0]       r_rr;

    state_t           w_state_nxt;
    logic [SC_W-1:0]  w_sync_nxt;
    logic [SKP_W-1:0] w_skp_nxt;
    logic [1:0]       w_rr_nxt;
    logic [7:0]       w_dat_nxt;
    logic             w_vld_nxt;
    logic             w_k_nxt;
    logic [1:0]       w_lane_nxt;

    logic             w_grant_vld;
    logic [1:0]       w_grant_idx;
    logic [7:0]       w_grant_byte;
    logic             w_skp_hit;

    // SKP slot: the last cycle of each SKP_INTERVAL window while the link stays up.
    assign w_skp_hit = (r_state == ST_ACTIVE) && enable &&
                       (r_skp_cnt == SKP_W'(SKP_INTERVAL - 1));

    // Round-robin search: walk from the highest offset down so the lowest
    // offset from r_rr that is valid wins.
    always_comb begin
        logic [1:0] cand;
        cand        = '0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = r_rr + 2'(k);
            if (valid_in[cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = cand;
            end
        end
    end

    always_comb begin
        case (w_grant_idx)
            2'd0:    w_grant_byte = in0;
            2'd1:    w_grant_byte = in1;
            2'd2:    w_grant_byte = in2;
            default: w_grant_byte = in3;
        endcase
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_sync_nxt  = r_sync_cnt;
        w_skp_nxt   = r_skp_cnt;
        w_rr_nxt    = r_rr;
        w_dat_nxt   = 8'h00;
        w_vld_nxt   = 1'b0;
        w_k_nxt     = 1'b0;
        w_lane_nxt  = 2'd0;
        ready_out   = 4'b0000;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_SYNC;
                    w_sync_nxt  = '0;
                end
            end
            ST_SYNC: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                    w_sync_nxt  = '0;
                end else begin
                    w_dat_nxt = COM_SYM;
                    w_k_nxt   = 1'b1;
                    if (r_sync_cnt == SC_W'(SYNC_COUNT - 1)) begin
                        w_state_nxt = ST_ACTIVE;
                        w_sync_nxt  = '0;
                    end else begin
                        w_sync_nxt = r_sync_cnt + SC_W'(1);
                    end
                end
            end
            ST_ACTIVE: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                    w_skp_nxt   = '0;
                    w_rr_nxt    = 2'd0;
                end else if (w_skp_hit) begin
                    // SKP pre-empts any grant; RR pointer is left alone.
                    w_dat_nxt = SKP_SYM;
                    w_k_nxt   = 1'b1;
                    w_skp_nxt = '0;
                end else begin
                    w_skp_nxt = r_skp_cnt + SKP_W'(1);
                    if (w_grant_vld) begin
                        ready_out  = 4'b0001 << w_grant_idx;
                        w_dat_nxt  = w_grant_byte;
                        w_vld_nxt  = 1'b1;
                        w_lane_nxt = w_grant_idx;
                        w_rr_nxt   = w_grant_idx + 2'd1;
                    end else begin
                        w_dat_nxt = IDL_SYM;
                        w_k_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_sync_cnt <= '0;
            r_skp_cnt  <= '0;
            r_rr       <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_sync_cnt <= w_sync_nxt;
            r_skp_cnt  <= w_skp_nxt;
            r_rr       <= w_rr_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            k_char    <= 1'b0;
            lane_sel  <= 2'd0;
            sync_done <= 1'b0;
        end else begin
            data_out  <= w_dat_nxt;
            valid_out <= w_vld_nxt;
            k_char    <= w_k_nxt;
            lane_sel  <= w_lane_nxt;
            sync_done <= (w_state_nxt == ST_ACTIVE);
        end
    end

    assign state_out = r_state;

`ifdef PHY_TX_SCHED_STATS_EN
    logic [15:0] r_cnt [4];
    logic [15:0] r_skp_stat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= 16'h0000;
            r_skp_stat <= 16'h0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (valid_in[i] && ready_out[i] && (r_cnt[i] != 16'hFFFF))
                    r_cnt[i] <= r_cnt[i] + 16'd1;
            end
            if (w_skp_hit && (r_skp_stat != 16'hFFFF))
                r_skp_stat <= r_skp_stat + 16'd1;
        end
    end

    assign cnt0    = r_cnt[0];
    assign cnt1    = r_cnt[1];
    assign cnt2    = r_cnt[2];
    assign cnt3    = r_cnt[3];
    assign skp_cnt = r_skp_stat;
`endif

endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// Purpose : randomized + directed bench for phy_tx_lane_sched against a cycle-level behavioural model.
// Latency : model predicts ready_out in-cycle and the registered byte stream one clk later.
// Backpr. : bench drives valid_in freely; only the model decides which source should be accepted.
module tb_phy_tx_lane_sched;

    localparam int         SYNC_COUNT   = 4;
    localparam int         SKP_INTERVAL = 16;
    localparam logic [7:0] COM_SYM      = 8'hBC;
    localparam logic [7:0] IDL_SYM      = 8'h7C;
    localparam logic [7:0] SKP_SYM      = 8'h1C;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] in0, in1, in2, in3;
    logic [3:0] valid_in;
    logic [3:0] ready_out;
    logic [7:0] data_out;
    logic       valid_out;
    logic       k_char;
    logic [1:0] lane_sel;
    logic [1:0] state_out;
    logic       sync_done;

    phy_tx_lane_sched #(
        .SYNC_COUNT  (SYNC_COUNT),
        .SKP_INTERVAL(SKP_INTERVAL),
        .COM_SYM     (COM_SYM),
        .IDL_SYM     (IDL_SYM),
        .SKP_SYM     (SKP_SYM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .in0      (in0),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .data_out (data_out),
        .valid_out(valid_out),
        .k_char   (k_char),
        .lane_sel (lane_sel),
        .state_out(state_out),
        .sync_done(sync_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Model: link mode (0 idle, 1 sync, 2 active), COMs sent in this burst,
    // ACTIVE cycles elapsed since entering ACTIVE, next RR start lane.
    int m_mode = 0;
    int m_com  = 0;
    int m_act  = 0;
    int m_rr   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".data"},  32'(data_out),  32'h00);
        chk({tag, ".valid"}, 32'(valid_out), 32'h0);
        chk({tag, ".k"},     32'(k_char),    32'h0);
        chk({tag, ".lane"},  32'(lane_sel),  32'h0);
        chk({tag, ".state"}, 32'(state_out), 32'h0);
        chk({tag, ".done"},  32'(sync_done), 32'h0);
        chk({tag, ".ready"}, 32'(ready_out), 32'h0);
    endtask

    // One clock: drive at negedge, check combinational ready, then check
    // registered outputs just after the posedge and commit the model.
    task automatic step(input logic en, input logic [3:0] v,
                        input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] bytes [4];
        int nm, nc, na, nr, ln;
        logic [3:0] er;
        logic [7:0] nd;
        logic nv, nk, found;
        logic [1:0] nl;

        @(negedge clk);
        enable = en; valid_in = v;
        in0 = b0; in1 = b1; in2 = b2; in3 = b3;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        #1;

        nm = m_mode; nc = m_com; na = m_act; nr = m_rr;
        er = 4'b0; nd = 8'h00; nv = 1'b0; nk = 1'b0; nl = 2'd0; found = 1'b0;
        case (m_mode)
            0: if (en) begin nm = 1; nc = 0; end
            1: begin
                if (!en) nm = 0;
                else begin
                    nd = COM_SYM; nk = 1'b1; nc = m_com + 1;
                    if (nc == SYNC_COUNT) begin nm = 2; na = 0; end
                end
            end
            default: begin
                if (!en) begin nm = 0; nr = 0; na = 0; end
                else begin
                    na = m_act + 1;
                    if (na % SKP_INTERVAL == 0) begin
                        nd = SKP_SYM; nk = 1'b1;
                    end else begin
                        for (int off = 0; off < 4; off++) begin
                            ln = (m_rr + off) % 4;
                            if (!found && v[ln]) begin
                                found = 1'b1; er[ln] = 1'b1; nd = bytes[ln];
                                nv = 1'b1; nl = 2'(ln); nr = (ln + 1) % 4;
                            end
                        end
                        if (!found) begin nd = IDL_SYM; nk = 1'b1; end
                    end
                end
            end
        endcase

        chk("ready", 32'(ready_out), 32'(er));

        @(posedge clk);
        #1;
        m_mode = nm; m_com = nc; m_act = na; m_rr = nr;
        chk("data",  32'(data_out),  32'(nd));
        chk("valid", 32'(valid_out), 32'(nv));
        chk("k",     32'(k_char),    32'(nk));
        chk("state", 32'(state_out), 32'(nm));
        chk("done",  32'(sync_done), 32'(nm == 2));
        if (nv) chk("lane", 32'(lane_sel), 32'(nl));
    endtask

    // Reset pulse placed between a posedge and the following negedge.
    task automatic async_reset_pulse();
        #1 reset = 1'b1;
        #1 check_reset_outputs("async_rst");
        #1 reset = 1'b0;
        m_mode = 0; m_com = 0; m_act = 0; m_rr = 0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; valid_in = 4'b0;
        in0 = 8'h00; in1 = 8'h00; in2 = 8'h00; in3 = 8'h00;
        #12;
        check_reset_outputs("reset");
        #10 reset = 1'b0;

        // Bring-up with nothing valid: 4 COMs then IDL fill.
        for (int i = 0; i < 8; i++) step(1'b1, 4'b0000, 8'h11, 8'h22, 8'h33, 8'h44);

        // All sources valid across two SKP windows.
        for (int i = 0; i < 40; i++) step(1'b1, 4'b1111, 8'hA0, 8'hA1, 8'hA2, 8'hA3);

        // Only lanes 1 and 3 valid.
        for (int i = 0; i < 20; i++) step(1'b1, 4'b1010, 8'hB0, 8'hB1, 8'hB2, 8'hB3);

        // Drop enable mid-ACTIVE, then re-enable for a full new sync.
        step(1'b0, 4'b1111, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
        step(1'b0, 4'b1111, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
        for (int i = 0; i < 10; i++) step(1'b1, 4'b1111, 8'hC0, 8'hC1, 8'hC2, 8'hC3);

        // Abort a sync burst via enable, then async reset mid-SYNC.
        step(1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        step(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        step(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        step(1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        step(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        step(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        step(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        async_reset_pulse();
        for (int i = 0; i < 10; i++) step(1'b1, 4'b0101, 8'hD0, 8'hD1, 8'hD2, 8'hD3);

        // Randomized traffic with occasional enable drops.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(39, 0) != 0), 4'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
